memory_map_seg: RTL and testbench

- Parametrised successor of the single-run loopback memory map: MMIO register file holding NUM_SEG segment write addresses, a go/done run controller, status and cycle-count readback.
- Sits between the top-level mmio_if adapter (flat ports below) and the DMA segment engine.
- Adds over the previous generation:
  - run state machine with sticky done
  - address lock while busy
  - registered read with valid
  - run cycle counter
  - unmapped-read handling

---
 rtl/memory_map_seg_pkg.sv | 35 +++
 rtl/memory_map_seg_ctrl.sv | 85 ++++++++
 rtl/memory_map_seg.sv | 106 ++++++++++
 tb/tb_memory_map_seg.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_map_seg_pkg.sv
// Shared types, control/status bit positions and register-offset helpers for memory_map_seg.
// Offsets are derived from BASE and NUM_SEG so the map tracks the segment count.
package memory_map_seg_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int CTRL_GO_BIT        = 0;
    localparam int CTRL_CLR_BIT       = 1;

    localparam int STATUS_BUSY_BIT    = 0;
    localparam int STATUS_DONE_BIT    = 1;
    localparam int STATUS_TIMEOUT_BIT = 2;

    localparam int CNT_W              = 64;

    function automatic int unsigned seg_addr(input int unsigned base, input int unsigned i);
        return base + 2 * (i + 1);
    endfunction

    function automatic int unsigned status_addr(input int unsigned base, input int unsigned num_seg);
        return base + 2 * (num_seg + 1);
    endfunction

    function automatic int unsigned cycles_addr(input int unsigned base, input int unsigned num_seg);
        return base + 2 * (num_seg + 2);
    endfunction

    function automatic int unsigned cv_addr(input int unsigned base, input int unsigned num_seg);
        return base + 2 * (num_seg + 3);
    endfunction

endpackage

// File: rtl/memory_map_seg_ctrl.sv
// Run controller: IDLE/RUN FSM, go pulse, saturating run-cycle counter, sticky done/timeout.
// Latency: go and busy one cycle after the start request; no backpressure (requests while running are dropped).
// Timeout supervision only when MEMORY_MAP_SEG_TIMEOUT_EN is defined.
module memory_map_seg_ctrl
    import memory_map_seg_pkg::*;
`ifdef MEMORY_MAP_SEG_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
)
`endif
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_req,
    input  logic             clr_req,
    input  logic             done,
    output logic             go,
    output logic             busy,
    output logic             done_sticky,
    output logic             timeout_sticky,
    output logic [CNT_W-1:0] cycles
);

    state_t           state;
    logic [CNT_W-1:0] cyc_inc;

    // The done cycle itself counts as a run cycle; the counter then stays frozen.
    assign cyc_inc = (&cycles) ? cycles : cycles + CNT_W'(1);

`ifndef MEMORY_MAP_SEG_TIMEOUT_EN
    assign timeout_sticky = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            go          <= 1'b0;
            busy        <= 1'b0;
            done_sticky <= 1'b0;
            cycles      <= '0;
`ifdef MEMORY_MAP_SEG_TIMEOUT_EN
            timeout_sticky <= 1'b0;
`endif
        end else begin
            go <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_req) begin
                        state       <= RUN;
                        go          <= 1'b1;
                        busy        <= 1'b1;
                        cycles      <= '0;
                        done_sticky <= 1'b0;
`ifdef MEMORY_MAP_SEG_TIMEOUT_EN
                        timeout_sticky <= 1'b0;
`endif
                    end else if (clr_req) begin
                        cycles      <= '0;
                        done_sticky <= 1'b0;
`ifdef MEMORY_MAP_SEG_TIMEOUT_EN
                        timeout_sticky <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    cycles <= cyc_inc;
                    if (done) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        done_sticky <= 1'b1;
                    end
`ifdef MEMORY_MAP_SEG_TIMEOUT_EN
                    else if (cyc_inc >= CNT_W'(TIMEOUT_CYCLES)) begin
                        state          <= IDLE;
                        busy           <= 1'b0;
                        timeout_sticky <= 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/memory_map_seg.sv
// MMIO register file for NUM_SEG segment addresses plus go/done run control and status/cycle/CV readback.
// Latency: writes take effect next cycle, reads return registered data with rd_valid one cycle after rd_en.
// No backpressure: every access completes; SEG writes during a run are dropped. Option: MEMORY_MAP_SEG_TIMEOUT_EN.
module memory_map_seg
    import memory_map_seg_pkg::*;
#(
    parameter int          ADDR_WIDTH = 64,
    parameter int          NUM_SEG    = 4,
    parameter int          MMIO_AW    = 16,
    parameter int unsigned BASE       = 'h0050
`ifdef MEMORY_MAP_SEG_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
`endif
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          mmio_wr_en,
    input  logic [MMIO_AW-1:0]            mmio_wr_addr,
    input  logic [63:0]                   mmio_wr_data,
    input  logic                          mmio_rd_en,
    input  logic [MMIO_AW-1:0]            mmio_rd_addr,
    output logic [63:0]                   mmio_rd_data,
    output logic                          mmio_rd_valid,
    output logic [NUM_SEG*ADDR_WIDTH-1:0] wr_addr,
    output logic                          go,
    input  logic                          done,
    input  logic [ADDR_WIDTH-1:0]         cv_value,
    output logic                          busy
);

    localparam int unsigned STATUS_A = status_addr(BASE, NUM_SEG);
    localparam int unsigned CYCLES_A = cycles_addr(BASE, NUM_SEG);
    localparam int unsigned CV_A     = cv_addr(BASE, NUM_SEG);

    logic [31:0]      wa;
    logic [31:0]      ra;
    logic             ctrl_wr;
    logic             done_sticky;
    logic             timeout_sticky;
    logic [CNT_W-1:0] cycles;
    logic [63:0]      rd_mux;

    assign wa      = 32'(mmio_wr_addr);
    assign ra      = 32'(mmio_rd_addr);
    assign ctrl_wr = mmio_wr_en && (wa == BASE);

    memory_map_seg_ctrl
`ifdef MEMORY_MAP_SEG_TIMEOUT_EN
        #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES))
`endif
    u_ctrl (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_req      (ctrl_wr && mmio_wr_data[CTRL_GO_BIT]),
        .clr_req        (ctrl_wr && mmio_wr_data[CTRL_CLR_BIT]),
        .done           (done),
        .go             (go),
        .busy           (busy),
        .done_sticky    (done_sticky),
        .timeout_sticky (timeout_sticky),
        .cycles         (cycles)
    );

    // Segment addresses are frozen while the engine is consuming them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr <= '0;
        end else if (mmio_wr_en && !busy) begin
            for (int i = 0; i < NUM_SEG; i++) begin
                if (wa == seg_addr(BASE, i))
                    wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH] <= mmio_wr_data[ADDR_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_SEG; i++) begin
            if (ra == seg_addr(BASE, i))
                rd_mux = 64'(wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
        end
        if (ra == STATUS_A) begin
            rd_mux[STATUS_BUSY_BIT]    = busy;
            rd_mux[STATUS_DONE_BIT]    = done_sticky;
            rd_mux[STATUS_TIMEOUT_BIT] = timeout_sticky;
        end
        if (ra == CYCLES_A)
            rd_mux = cycles;
        if (ra == CV_A)
            rd_mux = 64'(cv_value);
    end

    // Sampling the mux at the edge makes a same-cycle read see the pre-write value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mmio_rd_data  <= '0;
            mmio_rd_valid <= 1'b0;
        end else begin
            mmio_rd_valid <= mmio_rd_en;
            if (mmio_rd_en)
                mmio_rd_data <= rd_mux;
        end
    end

endmodule

// File: tb/tb_memory_map_seg.sv
// Randomized self-checking bench for memory_map_seg against a transaction-level register/run model.
// Timeout scenario is compiled in with MEMORY_MAP_SEG_TIMEOUT_EN.
module tb_memory_map_seg;

    localparam int          AW   = 64;
    localparam int          NSEG = 4;
    localparam logic [15:0] BASE = 16'h0050;
    localparam int          TO   = 100;

    localparam logic [15:0] A_CTRL   = BASE;
    localparam logic [15:0] A_STATUS = BASE + 16'd10;
    localparam logic [15:0] A_CYCLES = BASE + 16'd12;
    localparam logic [15:0] A_CV     = BASE + 16'd14;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 mmio_wr_en = 1'b0;
    logic [15:0]          mmio_wr_addr = '0;
    logic [63:0]          mmio_wr_data = '0;
    logic                 mmio_rd_en = 1'b0;
    logic [15:0]          mmio_rd_addr = '0;
    logic [63:0]          mmio_rd_data;
    logic                 mmio_rd_valid;
    logic [NSEG*AW-1:0]   wr_addr;
    logic                 go;
    logic                 done = 1'b0;
    logic [AW-1:0]        cv_value = '0;
    logic                 busy;

    int vecs = 0;
    int errs = 0;

    // Reference model state
    logic [63:0] m_seg [NSEG];
    bit          m_busy, m_done, m_to;
    logic [63:0] m_cycles;

    memory_map_seg #(
        .ADDR_WIDTH(AW), .NUM_SEG(NSEG), .MMIO_AW(16), .BASE(32'(BASE))
`ifdef MEMORY_MAP_SEG_TIMEOUT_EN
        , .TIMEOUT_CYCLES(TO)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .mmio_wr_en(mmio_wr_en), .mmio_wr_addr(mmio_wr_addr), .mmio_wr_data(mmio_wr_data),
        .mmio_rd_en(mmio_rd_en), .mmio_rd_addr(mmio_rd_addr),
        .mmio_rd_data(mmio_rd_data), .mmio_rd_valid(mmio_rd_valid),
        .wr_addr(wr_addr), .go(go), .done(done), .cv_value(cv_value), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] seg_a(input int i);
        return BASE + 16'(2 * (i + 1));
    endfunction

    function automatic logic [63:0] model_read(input logic [15:0] a);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < NSEG; i++)
            if (a == seg_a(i)) v = m_seg[i];
        if (a == A_STATUS) v = {61'd0, m_to, m_done, m_busy};
        if (a == A_CYCLES) v = m_cycles;
        if (a == A_CV)     v = cv_value;
        return v;
    endfunction

    function automatic logic [NSEG*AW-1:0] model_bus();
        logic [NSEG*AW-1:0] b;
        for (int i = 0; i < NSEG; i++) b[i*AW +: AW] = m_seg[i];
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NSEG; i++) m_seg[i] = '0;
        m_busy = 0; m_done = 0; m_to = 0; m_cycles = '0;
    endtask

    // Advance one clock with the currently driven inputs, update the model, check busy/go.
    task automatic tick();
        bit pre_busy, start;
        pre_busy = m_busy;
        start    = 0;
        if (pre_busy) begin
            if (m_cycles != '1) m_cycles = m_cycles + 1;
            if (done) begin
                m_busy = 0; m_done = 1;
            end
`ifdef MEMORY_MAP_SEG_TIMEOUT_EN
            else if (m_cycles >= 64'(TO)) begin
                m_busy = 0; m_to = 1;
            end
`endif
        end else if (mmio_wr_en && mmio_wr_addr == A_CTRL) begin
            if (mmio_wr_data[0]) begin
                start = 1; m_busy = 1; m_cycles = '0; m_done = 0; m_to = 0;
            end else if (mmio_wr_data[1]) begin
                m_cycles = '0; m_done = 0; m_to = 0;
            end
        end
        if (mmio_wr_en && !pre_busy)
            for (int i = 0; i < NSEG; i++)
                if (mmio_wr_addr == seg_a(i)) m_seg[i] = mmio_wr_data;
        @(negedge clk);
        vecs++;
        if (busy !== m_busy) begin
            errs++; $display("FAIL busy: got %b expected %b", busy, m_busy);
        end
        vecs++;
        if (go !== start) begin
            errs++; $display("FAIL go: got %b expected %b", go, start);
        end
    endtask

    task automatic mmio_write(input logic [15:0] a, input logic [63:0] d);
        mmio_wr_en = 1; mmio_wr_addr = a; mmio_wr_data = d;
        tick();
        mmio_wr_en = 0;
    endtask

    task automatic mmio_read(input logic [15:0] a, input string nm, output logic [63:0] got);
        logic [63:0] exp;
        exp = model_read(a);
        mmio_rd_en = 1; mmio_rd_addr = a;
        tick();
        mmio_rd_en = 0;
        got = mmio_rd_data;
        vecs++;
        if (mmio_rd_valid !== 1'b1) begin
            errs++; $display("FAIL %s rd_valid: got %b expected 1", nm, mmio_rd_valid);
        end
        vecs++;
        if (mmio_rd_data !== exp) begin
            errs++; $display("FAIL %s data @%h: got %h expected %h", nm, a, mmio_rd_data, exp);
        end
    endtask

    task automatic check_lit(input string nm, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++; $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic check_bus(input string nm);
        vecs++;
        if (wr_addr !== model_bus()) begin
            errs++; $display("FAIL %s wr_addr: got %h expected %h", nm, wr_addr, model_bus());
        end
    endtask

    task automatic test_reset();
        logic [63:0] got;
        model_reset();
        repeat (2) @(negedge clk);
        check_lit("reset_busy", 64'(busy), 0);
        check_lit("reset_go", 64'(go), 0);
        check_lit("reset_rd_valid", 64'(mmio_rd_valid), 0);
        check_lit("reset_rd_data", mmio_rd_data, 0);
        rst_n = 1;
        @(negedge clk);
        mmio_read(A_STATUS, "reset_status", got);
        check_lit("reset_status_lit", got, 0);
        check_bus("reset");
    endtask

    task automatic test_random_rw();
        logic [63:0] got, last;
        logic [15:0] a;
        for (int k = 0; k < 40; k++) begin
            a = 16'($urandom_range(32'h4C, 32'h64));
            if ($urandom_range(0, 1) == 0) begin
                if (a == A_CTRL) a = seg_a(0);
                mmio_write(a, {$urandom, $urandom});
            end else begin
                mmio_read(a, "rand_rd", got);
            end
        end
        check_bus("random_rw");
        // Same-cycle read/write of one register returns the old value; data then holds.
        mmio_wr_en = 1; mmio_wr_addr = seg_a(2); mmio_wr_data = {$urandom, $urandom};
        mmio_read(seg_a(2), "rd_during_wr", last);
        mmio_wr_en = 0;
        tick();
        check_lit("rd_valid_pulse", 64'(mmio_rd_valid), 0);
        check_lit("rd_data_hold", mmio_rd_data, last);
        mmio_read(seg_a(2), "rd_after_wr", got);
    endtask

    task automatic test_seg_rw();
        logic [63:0] got;
        for (int i = 0; i < NSEG; i++) mmio_write(seg_a(i), 64'h1000 * (i + 1));
        for (int i = 0; i < NSEG; i++) begin
            mmio_read(seg_a(i), "seg_rd", got);
            check_lit("seg_rd_lit", got, 64'h1000 * (i + 1));
        end
        check_bus("seg_rw");
        mmio_read(BASE + 16'd2, "base_plus_2", got);
        check_lit("base_plus_2_lit", got, 64'h1000);
        mmio_read(A_CTRL, "ctrl_rd", got);
        check_lit("ctrl_rd_lit", got, 0);
    endtask

    task automatic test_run();
        logic [63:0] got;
        cv_value = 64'hCAFE_0000_1234_5678;
        mmio_write(A_CTRL, 64'h1);
        tick();
        mmio_write(seg_a(1), 64'hDEAD);
        mmio_read(seg_a(1), "seg_locked", got);
        check_lit("seg_locked_lit", got, 64'h2000);
        for (int k = 0; k < 100 && m_cycles < 36; k++) tick();
        done = 1; tick(); done = 0;
        mmio_read(A_STATUS, "run_status", got);
        check_lit("run_status_lit", got, 64'd2);
        mmio_read(A_CYCLES, "run_cycles", got);
        check_lit("run_cycles_lit", got, 64'd37);
        mmio_read(A_CV, "run_cv", got);
        check_bus("run");
    endtask

    task automatic test_back_to_back();
        logic [63:0] got;
        mmio_write(A_CTRL, 64'h1);
        repeat (3) tick();
        mmio_write(A_CTRL, 64'h1);
        tick();
        done = 1; mmio_wr_en = 1; mmio_wr_addr = A_CTRL; mmio_wr_data = 64'h1;
        tick();
        done = 0; mmio_wr_en = 0;
        mmio_read(A_STATUS, "done_go_status", got);
        check_lit("done_go_status_lit", got, 64'd2);
        done = 1; tick(); done = 0;
        mmio_read(A_STATUS, "idle_done_status", got);
        mmio_write(A_CTRL, 64'h2);
        mmio_read(A_STATUS, "clr_status", got);
        check_lit("clr_status_lit", got, 0);
        mmio_read(A_CYCLES, "clr_cycles", got);
        mmio_write(A_CTRL, 64'h3);
        tick();
        mmio_write(A_CTRL, 64'h2);
        mmio_read(A_STATUS, "clr_in_run", got);
        check_lit("clr_in_run_lit", got, 64'd1);
        done = 1; tick(); done = 0;
        mmio_read(A_CYCLES, "b2b_cycles", got);
    endtask

    task automatic test_random_runs();
        logic [63:0] got;
        int len;
        for (int r = 0; r < 5; r++) begin
            cv_value = {$urandom, $urandom};
            for (int i = 0; i < NSEG; i++)
                if ($urandom_range(0, 1) == 1) mmio_write(seg_a(i), {$urandom, $urandom});
            mmio_write(A_CTRL, 64'h1);
            len = $urandom_range(1, 60);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 2) == 0)
                    mmio_read(16'($urandom_range(32'h50, 32'h60)), "run_rand_rd", got);
                else if ($urandom_range(0, 3) == 0)
                    mmio_write(seg_a($urandom_range(0, NSEG - 1)), {$urandom, $urandom});
                else
                    tick();
            end
            done = 1; tick(); done = 0;
            mmio_read(A_STATUS, "rr_status", got);
            mmio_read(A_CYCLES, "rr_cycles", got);
            mmio_read(A_CV, "rr_cv", got);
            check_bus("rand_run");
        end
    endtask

    task automatic test_reset_midrun();
        logic [63:0] got;
        mmio_write(A_CTRL, 64'h1);
        repeat (5) tick();
        rst_n = 0;
        #1;
        check_lit("arst_busy", 64'(busy), 0);
        check_lit("arst_go", 64'(go), 0);
        check_lit("arst_wr_addr", 64'(wr_addr == '0), 1);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        mmio_read(A_STATUS, "post_rst_status", got);
        check_lit("post_rst_status_lit", got, 0);
        mmio_read(seg_a(0), "post_rst_seg0", got);
        check_lit("post_rst_seg0_lit", got, 0);
        mmio_read(16'h00F0, "unmapped", got);
        check_lit("unmapped_lit", got, 0);
    endtask

`ifdef MEMORY_MAP_SEG_TIMEOUT_EN
    task automatic test_timeout();
        logic [63:0] got;
        mmio_write(A_CTRL, 64'h1);
        for (int k = 0; k < TO; k++) tick();
        check_lit("timeout_busy", 64'(busy), 0);
        mmio_read(A_STATUS, "timeout_status", got);
        check_lit("timeout_status_lit", got, 64'd4);
        mmio_write(A_CTRL, 64'h2);
        mmio_read(A_STATUS, "timeout_clr", got);
        check_lit("timeout_clr_lit", got, 0);
    endtask
`endif

    initial begin
        test_reset();
        test_random_rw();
        test_seg_rw();
        test_run();
        test_back_to_back();
        test_random_runs();
        test_reset_midrun();
`ifdef MEMORY_MAP_SEG_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
